// File: rtl/stage_mem.sv
// Memory-access stage: req/ack data bus, byte lanes, load extraction.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating.
module stage_mem #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            MemReq_mi,
   input  logic            MemRW_mi,
   input  logic [2:0]      funct3_mi,
   input  logic            RegWEn_mi,
   input  logic [1:0]      WBSel_mi,
   input  logic [XLEN-1:0] alu_mi,
   input  logic [XLEN-1:0] RegDataB_mi,
   input  logic [4:0]      AddrD_mi,
   input  logic [XLEN-1:0] pc_mi,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   output logic [3:0]      dmem_be_o,
   input  logic            dmem_ack_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic            stall_o,
   output logic            RegWEn_mo,
   output logic [1:0]      WBSel_mo,
   output logic [XLEN-1:0] alu_mo,
   output logic [XLEN-1:0] memdata_mo,
   output logic [4:0]      AddrD_mo,
   output logic [XLEN-1:0] pc_mo
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic            misalign_mo
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, state_nx;

   logic [1:0]      off;
   logic [1:0]      eoff;
   logic            sz_b;
   logic            sz_h;
   logic            misal;
   logic            legal;
   logic            acc;
   logic            busy;
   logic            sgn;
   logic [XLEN-1:0] rsh;
   logic [XLEN-1:0] ld_data;

   assign off  = alu_mi[1:0];
   assign busy = (state == BUSY);
   assign sgn  = ~funct3_mi[2];

   // Stores only define 000/001; loads also have the unsigned 1xx forms.
   always_comb begin
      sz_b = 1'b0;
      sz_h = 1'b0;
      if (MemRW_mi) begin
         sz_b = (funct3_mi == 3'b000);
         sz_h = (funct3_mi == 3'b001);
      end else begin
         sz_b = (funct3_mi[1:0] == 2'b00);
         sz_h = (funct3_mi[1:0] == 2'b01);
      end
   end

   assign misal = (sz_h & off[0]) | (~sz_b & ~sz_h & (off != 2'b00));

`ifdef MEM_MISALIGN_TRAP_EN
   assign legal = ~misal;
`else
   assign legal = 1'b1;
`endif

   always_comb begin
      eoff = 2'b00;
      if (sz_b)
         eoff = off;
      else if (sz_h)
         eoff = {off[1], 1'b0};
   end

   assign acc = MemReq_mi & legal;

   assign dmem_req_o  = busy | acc;
   assign dmem_we_o   = dmem_req_o & MemRW_mi;
   assign dmem_addr_o = {alu_mi[XLEN-1:2], 2'b00};
   assign stall_o     = acc & ~(busy & dmem_ack_i);

   always_comb begin
      dmem_be_o    = 4'b1111;
      dmem_wdata_o = RegDataB_mi;
      if (MemRW_mi) begin
         if (sz_b) begin
            dmem_be_o    = 4'b0001 << eoff;
            dmem_wdata_o = {4{RegDataB_mi[7:0]}};
         end else if (sz_h) begin
            dmem_be_o    = 4'b0011 << eoff;
            dmem_wdata_o = {2{RegDataB_mi[15:0]}};
         end
      end
   end

   assign rsh = dmem_rdata_i >> {eoff, 3'b000};

   always_comb begin
      ld_data = dmem_rdata_i;
      if (sz_b)
         ld_data = {{24{sgn & rsh[7]}}, rsh[7:0]};
      else if (sz_h)
         ld_data = {{16{sgn & rsh[15]}}, rsh[15:0]};
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (acc) state_nx = BUSY;
         BUSY: if (dmem_ack_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         RegWEn_mo  <= 1'b0;
         WBSel_mo   <= '0;
         alu_mo     <= '0;
         memdata_mo <= '0;
         AddrD_mo   <= '0;
         pc_mo      <= '0;
      end else if (!stall_o) begin
         RegWEn_mo  <= RegWEn_mi & ~(MemReq_mi & ~legal);
         WBSel_mo   <= WBSel_mi;
         alu_mo     <= alu_mi;
         AddrD_mo   <= AddrD_mi;
         pc_mo      <= pc_mi;
         memdata_mo <= (acc & ~MemRW_mi) ? ld_data : '0;
      end else begin
         RegWEn_mo  <= 1'b0;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   // Trap flag lives for exactly the one slot of the faulting instruction.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i)
         misalign_mo <= 1'b0;
      else
         misalign_mo <= ~stall_o & MemReq_mi & misal;
   end
`endif

endmodule
